pq_req_arbiter: RTL and testbench
=================================

Name: pq_req_arbiter

Overview:
- Shares one hardware priority queue (kv_t <key,value> entries from pq_pkg, capacity PQ_CAPACITY) among NREQ requesters.
- Round-robin arbitration grants one requester at a time.
- Sequences a single enqueue or dequeue on the queue, waits for the queue to finish, then returns a response and ack to the granted requester.
- Sits between client logic and any HWPQ implementation that uses the standard pq_pkg interface.

Parameters:
- NREQ, 4, number of requesters (2..8); index width IW = $clog2(NREQ).
- KVW, KEY_WIDTH+VAL_WIDTH (8), width of one kv_t, taken from pq_pkg.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request, held high until its ack.
- op  in  NREQ  per-requester operation: 0 = enqueue, 1 = dequeue; stable while req is high.
- wkv  in  NREQ*KVW  per-requester kv_t to enqueue; slice i = bits [i*KVW +: KVW]; stable while req is high.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with ack: 1 = enqueue rejected because the queue was full, or dequeue rejected because it was empty.
- rkv  out  KVW  dequeued kv_t, valid with ack on a dequeue.
- gnt_idx  out  IW  index of the current or most recent grant (debug).
- pq_enq  out  1  one-cycle enqueue strobe to the queue.
- pq_deq  out  1  one-cycle dequeue strobe to the queue.
- pq_kvi  out  KVW  kv_t presented with pq_enq.
- pq_kvo  in  KVW  queue head; valid when pq_busy=0 and pq_empty=0.
- pq_busy  in  1  queue is processing an operation.
- pq_full  in  1  queue holds PQ_CAPACITY entries.
- pq_empty  in  1  queue holds 0 entries.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, rr_ptr=0, done_mask=0, gnt_idx=0.
  - ack=0, err=0, pq_enq=0, pq_deq=0.
  - pq_kvi=KV_EMPTY, rkv=KV_EMPTY.
  - Reset mid-operation abandons the transaction with no ack. A strobe already issued is not retracted.
- Eligibility:
  - elig = req & ~done_mask.
  - done_mask[i] is set in RESP for the granted index and cleared on any cycle where req[i]=0. This enforces a 4-phase handshake, so a requester is never regranted on its own stale req.
- Round-robin: pick the first set bit of elig searching from rr_ptr upward, wrapping modulo NREQ. In RESP, rr_ptr <= gnt_idx+1 mod NREQ (wrap NREQ-1 -> 0).
- FSM:
  - IDLE: if elig!=0, latch gnt_idx, the granted op, and the wkv slice; go to ISSUE. Otherwise stay.
  - ISSUE:
    - If pq_busy=1, stay.
    - Else if (op=enq and pq_full) or (op=deq and pq_empty): set err_r=1, rkv_r=KV_EMPTY, go to RESP with no strobe.
    - Else if deq: capture rkv_r=pq_kvo, pulse pq_deq, go to WAIT.
    - Else (enq): pulse pq_enq with pq_kvi=latched kv, go to WAIT.
    - err_r=0 on both strobe paths.
  - WAIT: minimum one cycle; stay while pq_busy=1; go to RESP when pq_busy=0.
  - RESP: ack[gnt_idx]=1 for exactly one cycle; err=err_r, rkv=rkv_r; update rr_ptr and done_mask; go to IDLE.
- Outputs are registered (Moore):
  - ack, err, pq_enq and pq_deq are 0 outside their defined cycles.
  - rkv and err hold their values until the next RESP.
- Latency: req high at edge t (in IDLE) -> ISSUE t+1 -> WAIT t+2 -> RESP/ack t+3 when the queue is not busy. Minimum 3 cycles, plus the queue's busy time. A rejected op acks at t+2.
- Exactly one queue strobe per granted non-rejected transaction. pq_enq and pq_deq are never asserted together.
- Simultaneous requests: one grant per transaction; the others wait with req held.
- A request that rises during a transaction is considered at the next IDLE.
- Changing op or wkv while req is high and ungranted is allowed. After grant, the latched copy is used.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> ack=0, pq_enq=pq_deq=0, rkv=8'hF0 (KV_EMPTY, KEYINF=4'hF, VAL0=4'h0), gnt_idx=0.
- Single enqueue: req[2]=1, op[2]=0, wkv slice2=8'h35, queue idle -> pq_enq one cycle with pq_kvi=8'h35 at t+1; ack=4'b0100 at t+3 with err=0.
- Dequeue of min: after enqueuing 8'h35, 8'h12, 8'h77, req[1] deq -> ack[1]=1, rkv=8'h12, err=0.
- Round-robin fairness: req=4'b1111 all enq, rr_ptr=0, requester drops req after ack and re-raises -> grant order 0,1,2,3,0. A single persistent requester 3 alone -> granted once per req high-low-high cycle.
- Boundaries:
  - Dequeue with pq_empty=1 -> no pq_deq, ack at t+2, err=1, rkv=8'hF0.
  - Enqueue with pq_full=1 -> no pq_enq, err=1.
  - pq_busy held 5 cycles after strobe -> ack delayed until the cycle after pq_busy falls.
- Reset mid-transaction: rst during WAIT -> no ack, state IDLE. The next request is served normally starting from rr_ptr=0.

Source files
------------

// File: rtl/pq_req_arbiter.sv
// pq_req_arbiter: round-robin arbiter sharing one priority queue among NREQ requesters
package pq_pkg;
    localparam int KEY_WIDTH = 4;
    localparam int VAL_WIDTH = 4;
    localparam int PQ_CAPACITY = 8;
    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;
    localparam logic [KEY_WIDTH-1:0] KEYINF = '1;
    localparam logic [VAL_WIDTH-1:0] VAL0 = '0;
    localparam kv_t KV_EMPTY = '{key: KEYINF, val: VAL0};
endpackage

module pq_req_arbiter
    import pq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int KVW = KEY_WIDTH + VAL_WIDTH,
    localparam int IW = $clog2(NREQ)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   op,
    input  logic [NREQ*KVW-1:0] wkv,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic [KVW-1:0]    rkv,
    output logic [IW-1:0]     gnt_idx,
    output logic              pq_enq,
    output logic              pq_deq,
    output logic [KVW-1:0]    pq_kvi,
    input  logic [KVW-1:0]    pq_kvo,
    input  logic              pq_busy,
    input  logic              pq_full,
    input  logic              pq_empty
);
    localparam logic [KVW-1:0] KV_NONE = KV_EMPTY;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, pick, cand;
    logic [NREQ-1:0] done_mask, elig, gnt_oh;
    logic            op_r, err_r, rej, hit;
    logic [KVW-1:0]  kv_r, rkv_r;

    assign gnt_oh = NREQ'(1) << gnt_idx;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // round-robin pick from rr_ptr upward, rejection test and next-state logic
    always_comb begin
        elig = req & ~done_mask;
        pick = rr_ptr;
        hit = 1'b0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (!hit && elig[cand]) begin
                pick = cand;
                hit = 1'b1;
            end
        end
        rej = op_r ? pq_empty : pq_full;
        state_n = state;
        case (state)
            IDLE:    state_n = hit ? ISSUE : IDLE;
            ISSUE:   state_n = pq_busy ? ISSUE : rej ? RESP : WAIT;
            WAIT:    state_n = pq_busy ? WAIT : RESP;
            default: state_n = IDLE;
        endcase
    end

    // grant latch, queue strobes, response registers and fairness bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            done_mask <= '0;
            gnt_idx   <= '0;
            op_r      <= 1'b0;
            kv_r      <= KV_NONE;
            err_r     <= 1'b0;
            rkv_r     <= KV_NONE;
            ack       <= '0;
            err       <= 1'b0;
            rkv       <= KV_NONE;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            pq_kvi    <= KV_NONE;
        end else begin
            ack       <= '0;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            done_mask <= (done_mask & req) | ((state == RESP) ? gnt_oh : '0);
            if (state == IDLE && hit) begin
                gnt_idx <= pick;
                op_r    <= op[pick];
                kv_r    <= wkv[int'(pick)*KVW +: KVW];
            end
            if (state == ISSUE && !pq_busy) begin
                err_r  <= rej;
                rkv_r  <= rej ? KV_NONE : op_r ? pq_kvo : rkv_r;
                pq_enq <= !rej && !op_r;
                pq_deq <= !rej && op_r;
                if (!rej && !op_r)
                    pq_kvi <= kv_r;
            end
            if (state == RESP) begin
                ack    <= gnt_oh;
                err    <= err_r;
                rkv    <= rkv_r;
                rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pq_req_arbiter.sv
// tb_pq_req_arbiter: directed and randomized checks of the arbiter against a behavioural queue model
module tb_pq_req_arbiter;
    localparam int NR  = 4;
    localparam int KW  = 8;
    localparam int CAP = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   op = '0;
    logic [NR*KW-1:0] wkv = '0;
    logic [NR-1:0]   ack;
    logic            err;
    logic [KW-1:0]   rkv;
    logic [1:0]      gnt_idx;
    logic            pq_enq, pq_deq;
    logic [KW-1:0]   pq_kvi;
    logic [KW-1:0]   pq_kvo = 8'hF0;
    logic            pq_busy;
    logic            pq_full = 1'b0;
    logic            pq_empty = 1'b1;

    int checks = 0;
    int errors = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    int enq_cnt = 0;
    int deq_cnt = 0;
    int both_cnt = 0;
    logic [KW-1:0] last_kvi = '0;
    logic [KW-1:0] mem[$];
    logic [KW-1:0] ref_q[$];
    int order[5];
    int nacks, cyc, g, cnt;
    logic [NR-1:0] raise;

    pq_req_arbiter #(.NREQ(NR)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .wkv(wkv),
        .ack(ack), .err(err), .rkv(rkv), .gnt_idx(gnt_idx),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
        .pq_kvo(pq_kvo), .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty)
    );

    always #5 clk = ~clk;

    // queue answers busy in the strobe cycle itself and for busy_len cycles in total
    assign pq_busy = ((pq_enq || pq_deq) && busy_len > 0) || busy_cnt > 0;

    function automatic int find_pos(input logic [KW-1:0] kv);
        for (int j = 0; j < mem.size(); j++)
            if (mem[j][7:4] > kv[7:4]) return j;
        return mem.size();
    endfunction

    // behavioural priority queue: kept sorted by key, ties in arrival order
    always @(posedge clk) begin
        if (rst) begin
            mem.delete();
        end else begin
            if (pq_enq) mem.insert(find_pos(pq_kvi), pq_kvi);
            if (pq_deq && mem.size() > 0) void'(mem.pop_front());
        end
        pq_kvo   <= (mem.size() > 0) ? mem[0] : 8'hF0;
        pq_empty <= (mem.size() == 0);
        pq_full  <= (mem.size() == CAP);
        busy_cnt <= rst ? 0 : ((pq_enq || pq_deq) && busy_len > 0) ? busy_len - 1 : (busy_cnt > 0) ? busy_cnt - 1 : 0;
        if (pq_enq) begin
            enq_cnt  <= enq_cnt + 1;
            last_kvi <= pq_kvi;
        end
        if (pq_deq) deq_cnt <= deq_cnt + 1;
        if (pq_enq && pq_deq) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        ref_q.delete();
    endtask

    // one request from requester i; expectations come from the reference list ref_q
    task automatic do_txn(input int i, input logic o, input logic [KW-1:0] kv);
        logic exp_err;
        logic [KW-1:0] exp_rkv;
        int mi, n, sn, e0, d0;
        logic got;
        exp_rkv = 8'hF0;
        if (o) begin
            exp_err = (ref_q.size() == 0);
            if (!exp_err) begin
                mi = 0;
                for (int j = 1; j < ref_q.size(); j++)
                    if (ref_q[j][7:4] < ref_q[mi][7:4]) mi = j;
                exp_rkv = ref_q[mi];
                ref_q.delete(mi);
            end
        end else begin
            exp_err = (ref_q.size() == CAP);
            if (!exp_err) ref_q.push_back(kv);
        end
        e0 = enq_cnt;
        d0 = deq_cnt;
        op[i] = o;
        wkv[i*KW +: KW] = kv;
        req[i] = 1'b1;
        n = 0;
        sn = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((pq_enq || pq_deq) && sn == 0) sn = n;
            if (ack != '0) got = 1'b1;
        end
        chk("ack_seen", got, 1);
        chk("ack", ack, 32'(1) << i);
        chk("gnt_idx", gnt_idx, i);
        chk("err", err, exp_err);
        chk("latency", n, exp_err ? 3 : 4 + busy_len);
        chk("strobe_at", sn, exp_err ? 0 : 2);
        chk("enq_strobes", enq_cnt - e0, (!o && !exp_err) ? 1 : 0);
        chk("deq_strobes", deq_cnt - d0, (o && !exp_err) ? 1 : 0);
        if (o || exp_err) chk("rkv", rkv, exp_rkv);
        if (!o && !exp_err) chk("pq_kvi", last_kvi, kv);
        req[i] = 1'b0;
        @(negedge clk);
        chk("ack_pulse", ack, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset(2);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_enq", pq_enq, 0);
        chk("rst_deq", pq_deq, 0);
        chk("rst_rkv", rkv, 8'hF0);
        chk("rst_kvi", pq_kvi, 8'hF0);
        chk("rst_gnt", gnt_idx, 0);
        repeat (3) @(negedge clk);
        chk("idle_ack", ack, 0);
        do_txn(2, 1'b0, 8'h35);
        do_txn(0, 1'b0, 8'h12);
        do_txn(3, 1'b0, 8'h77);
        do_txn(1, 1'b1, 8'h00);
        chk("deq_min", rkv, 8'h12);
        do_reset(1);
        do_txn(1, 1'b1, 8'h00);
        chk("empty_rkv", rkv, 8'hF0);
        chk("empty_err", err, 1);
        for (int k = 0; k < CAP; k++) do_txn(k % NR, 1'b0, 8'($urandom));
        do_txn(0, 1'b0, 8'h44);
        chk("full_err", err, 1);
        do_txn(2, 1'b1, 8'h00);
        busy_len = 5;
        do_txn(3, 1'b0, 8'h5A);
        do_txn(0, 1'b1, 8'h00);
        busy_len = 0;
        do_reset(1);
        for (int k = 0; k < NR; k++) begin
            op[k] = 1'b0;
            wkv[k*KW +: KW] = 8'(16 * k + 3);
        end
        req = 4'b1111;
        raise = '0;
        nacks = 0;
        cyc = 0;
        while (nacks < 5 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            req = req | raise;
            raise = '0;
            if (ack != '0) begin
                g = 0;
                for (int k = 0; k < NR; k++) if (ack[k]) g = k;
                order[nacks] = g;
                nacks++;
                req[g] = 1'b0;
                raise[g] = 1'b1;
            end
        end
        req = '0;
        chk("fair_acks", nacks, 5);
        for (int k = 0; k < 5; k++) chk("fair_order", order[k], k % NR);
        do_reset(1);
        op[3] = 1'b0;
        wkv[3*KW +: KW] = 8'h66;
        req[3] = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ack[3]) cnt++;
        end
        chk("persist_once", cnt, 1);
        req[3] = 1'b0;
        @(negedge clk);
        req[3] = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack[3]) cnt++;
        end
        chk("persist_regrant", cnt, 1);
        req = '0;
        do_reset(1);
        do_txn(1, 1'b0, 8'h21);
        busy_len = 5;
        op[2] = 1'b0;
        wkv[2*KW +: KW] = 8'h48;
        req[2] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        ref_q.delete();
        busy_len = 0;
        chk("midrst_gnt", gnt_idx, 0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack != '0) cnt++;
        end
        chk("midrst_noack", cnt, 0);
        op[1] = 1'b0;
        op[3] = 1'b0;
        req = 4'b1010;
        nacks = 0;
        cyc = 0;
        while (nacks < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                if (nacks == 0) chk("midrst_first", ack, 4'b0010);
                nacks++;
                req = req & ~ack;
            end
        end
        chk("midrst_acks", nacks, 2);
        req = '0;
        do_reset(1);
        for (int t = 0; t < 60; t++) begin
            busy_len = $urandom_range(0, 3);
            do_txn($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        busy_len = 0;
        chk("both_strobes", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
